// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD feeder: FSM states, widths,
// iteration count and the display codes used for out-of-range values.
package bcd_pkg;

    localparam int BIN_W   = 16;
    localparam int DIGITS  = 4;
    localparam int ITER    = 16;
    localparam int CNT_W   = 5;
    localparam int BCD_MAX = 9999;

    localparam logic [BIN_W-1:0] BCD_ERR = 16'hEEEE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_feeder.sv
// Converts a 16-bit binary value into four packed BCD digits with a
// sequential double-dabble (one step per cycle) and presents the result to
// a 7-segment driver with a one-cycle write strobe.
//
// Handshake: req is level-sampled on every rising edge; it is accepted only
// when busy=0 (state IDLE), and that edge captures bin. While busy=1 req is
// ignored entirely (no queueing). dout is valid whenever we=1 and holds its
// value until the next conversion finishes or reset clears it.
//
// Build option: define BCD_OVF_ERR_EN to show "EEEE" for inputs above 9999;
// without it such inputs are passed through to dout unchanged.
module bin2bcd_feeder
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin,
    input  logic             req,
    output logic             busy,
    output logic [BIN_W-1:0] dout,
    output logic             we,
    output state_t           state_dbg
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] acc;
    logic [BIN_W-1:0] sh;
    logic [BIN_W-1:0] bin_q;
    logic [BIN_W-1:0] acc_adj;
    logic [BIN_W-1:0] acc_step;
    logic [BIN_W-1:0] sh_step;
    logic [BIN_W-1:0] result;
    logic             last_step;
    logic             ovf;

    // One add-3 correction per BCD digit of the accumulator.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (acc[4*g +: 4]),
            .dout (acc_adj[4*g +: 4])
        );
    end

    // The accumulator MSB shifted out is irrelevant: 9999 fits in 16 BCD bits.
    assign {acc_step, sh_step} = {acc_adj, sh} << 1;

    assign last_step = (cnt == CNT_W'(ITER - 1));

    // Range check uses the captured copy so a changing bin cannot affect it.
    assign ovf = (bin_q > BIN_W'(BCD_MAX));

`ifdef BCD_OVF_ERR_EN
    assign result = ovf ? BCD_ERR : acc_step;
`else
    assign result = ovf ? bin_q : acc_step;
`endif

    assign busy      = (state != IDLE);
    assign we        = (state == DONE);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, 16 steps in CONV, one strobe cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = CONV;
            CONV:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift-and-correct during CONV, publish result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            acc   <= '0;
            sh    <= '0;
            bin_q <= '0;
            dout  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        bin_q <= bin;
                        sh    <= bin;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CONV: begin
                    acc <= acc_step;
                    sh  <= sh_step;
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        dout <= result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/bin2bcd_feeder.md
BIN2BCD_FEEDER -- requirements
Module: bin2bcd_feeder

Interface
- REQ-001: The block SHALL use one clock; reset is synchronous and active-high.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: rst  input  1  synchronous, active-high reset.
- REQ-004: bin  input  16  unsigned binary value to convert; sampled only on the accepting edge.
- REQ-005: req  input  1  conversion request; level-sampled each edge.
- REQ-006: busy  output  1  high while a conversion is in flight; requests are not accepted while it is high.
- REQ-007: dout  output  16  four packed BCD digits: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units; feeds the 7-segment driver's 16-bit data input.
- REQ-008: we  output  1  one-cycle write strobe to the 7-segment driver; dout is valid whenever we is high.

Function
- REQ-009: The FSM SHALL have exactly three states: IDLE, CONV and DONE.
- REQ-010: In IDLE, req=1 at a rising edge SHALL be the accepting edge: bin is captured, a 5-bit iteration counter is cleared, and the state moves to CONV.
- REQ-011: CONV SHALL perform one double-dabble step per cycle: on each 4-bit digit of the 16-bit BCD accumulator, add 3 where the digit is >=5, then shift {accumulator, binary} left by one bit.
- REQ-012: CONV SHALL run exactly 16 steps; on the 16th step the final result is registered into dout and the state moves to DONE.
- REQ-013: DONE SHALL last exactly one cycle, with we=1, and then return to IDLE.
- REQ-014: Latency: we SHALL be high in the 17th cycle after the accepting edge, regardless of the input value.
- REQ-015: busy SHALL be 1 in the CONV and DONE states and 0 in IDLE.
- REQ-016: req while busy=1, including during DONE, SHALL be ignored; it is neither queued nor merged.
- REQ-017: req held high continuously SHALL start a new conversion on the first IDLE edge after DONE, giving back-to-back conversions every 18 cycles.
- REQ-018: dout SHALL hold its last value between conversions; we SHALL be 0 outside DONE.
- REQ-019: Inputs 0..9999 SHALL produce the exact BCD encoding of bin.
- REQ-020: Handling of inputs >9999 SHALL be set by REQ-024; latency is unchanged in either case.

Reset
- REQ-021: rst=1 at an edge SHALL force IDLE, dout=16'h0000, we=0, busy=0, counter=0, accumulator=0.
- REQ-022: Reset during CONV or DONE SHALL abort the conversion, and no we pulse SHALL follow.
- REQ-023: With rst=1 and req=1 at the same edge, reset SHALL win and the request is dropped.

Configuration
- REQ-024: Macro BCD_OVF_ERR_EN SHALL control out-of-range handling, as follows:
  - Defined: bin >9999 yields dout=16'hEEEE, displayed as "EEEE".
  - Undefined: bin >9999 yields dout=bin unchanged, displayed as raw hex.
  - In both cases the overflow decision SHALL be made on the captured value.

Structure
- REQ-025: Package bcd_pkg SHALL hold the following shared definitions:
  - the state enum (IDLE/CONV/DONE);
  - BIN_W=16 and DIGITS=4;
  - ITER=16;
  - BCD_MAX=9999;
  - BCD_ERR=16'hEEEE.
- REQ-026: A combinational sub-module bcd_add3 (4-bit in, 4-bit out: out = in>=5 ? in+3 : in) SHALL be instantiated once per digit; there is no other hierarchy.

Verification
- REQ-027: bin=16'd1234, req pulsed once -> busy high for 17 cycles, a single we pulse in cycle 17, dout=16'h1234.
- REQ-028: The bench SHALL cover the following boundary values:
  - bin=0 -> dout=16'h0000 with we pulsed;
  - bin=9999 -> dout=16'h9999;
  - bin=5 -> dout=16'h0005.
- REQ-029: bin=10000 -> dout=16'hEEEE with BCD_OVF_ERR_EN defined, or 16'h2710 without it; latency is 17 cycles in both builds.
- REQ-030: bin=42 accepted, then req=1 with bin=77 on cycles 3..17 -> only one we, with dout=16'h0042; a subsequent IDLE req with bin=77 -> dout=16'h0077.
- REQ-031: rst asserted on cycle 8 of a conversion of bin=500 -> no we, dout=16'h0000, busy=0 on the next cycle.
- REQ-032: req held high with bin=1 -> we pulses every 18 cycles, each with dout=16'h0001.
